capture_ctrl_mc: RTL and testbench
==================================

Name: capture_ctrl_mc

Overview:
- Parametrised multi-channel successor to the single-source logging control used beside the QPSK system.
- Captures one software-selected channel out of NUM_CH equalizer/tap/BER data streams into an internal dual-port buffer of RAM_DEPTH words.
- Start modes: immediate, delayed and triggered. Samples are decimated against each channel's rate strobe.
- The register file reads the buffer back at any time through a 1-cycle-latency read port.

Parameters:
- NUM_CH, 4, number of input channels (must be >= 2).
- NBT_CH, 32, bits per channel sample and per buffer word.
- RAM_DEPTH, 1024, buffer depth in words (power of 2, >= 4).
- NBT_DELAY, 16, width of the start-delay count.
- NBT_DEC, 8, width of the decimation count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_data  in  NUM_CH*NBT_CH  packed channels; channel k at [k*NBT_CH +: NBT_CH].
- i_valid  in  NUM_CH  per-channel sample strobe (rate control); bit k qualifies channel k.
- i_ch_sel  in  $clog2(NUM_CH)  channel to capture; latched at start.
- i_mode  in  2  capture mode: 00 immediate, 01 delayed, 10 triggered, 11 reserved (behaves as 00); latched at start.
- i_delay  in  NBT_DELAY  delay in clk cycles for mode 01; latched at start.
- i_decim  in  NBT_DEC  keep 1 of (i_decim+1) valid samples; latched at start.
- i_trig  in  1  external trigger; rising edge is used in mode 10.
- i_start  in  1  one-cycle arm pulse.
- i_abort  in  1  one-cycle abort pulse.
- i_rd_en  in  1  read request.
- i_rd_adrs  in  $clog2(RAM_DEPTH)  read address.
- o_rd_data  out  NBT_CH  read data.
- o_rd_valid  out  1  high one cycle after an i_rd_en cycle.
- o_busy  out  1  high in WAIT or CAPTURE.
- o_done  out  1  buffer full.
- o_wr_count  out  $clog2(RAM_DEPTH)+1  number of words written in the current capture.

Behaviour:
- Reset (i_reset=0, asynchronous): FSM to IDLE. o_busy=0, o_done=0, o_wr_count=0, o_rd_data=0, o_rd_valid=0. Delay, decimation and edge registers cleared. Buffer contents undefined.
- FSM states: IDLE, WAIT, CAPTURE, DONE.
- IDLE/DONE + i_start:
  - Latch ch_sel, mode, delay and decim; clear o_wr_count and o_done.
  - Mode 00/11: go to CAPTURE. Mode 01: go to WAIT with delay counter = i_delay. Mode 10: go to WAIT armed for a trigger.
- WAIT, mode 01: counter decrements each cycle; go to CAPTURE the cycle after it reads 0. i_delay=0 behaves exactly like mode 00.
- WAIT, mode 10:
  - i_trig is registered once; the rising edge is trig_q=1 while trig_q_d=0.
  - Go to CAPTURE on the cycle the edge is detected.
  - i_trig held high at start does not trigger; a fresh rising edge is required.
- CAPTURE:
  - Decimation counter is zeroed on entry.
  - On each cycle with i_valid[ch]=1: if counter==0, write i_data[ch] to address o_wr_count[$clog2(RAM_DEPTH)-1:0] and increment o_wr_count.
  - Counter increments on every valid cycle and wraps to 0 after reaching decim. The first valid sample after entry is therefore always written.
  - i_valid on non-selected channels is ignored.
- When the write that makes o_wr_count==RAM_DEPTH occurs: go to DONE, o_done=1 the next cycle, o_busy=0. No further writes; o_wr_count holds RAM_DEPTH.
- i_abort in WAIT or CAPTURE: go to IDLE the next cycle, o_busy=0, o_done=0, o_wr_count holds. i_abort in IDLE/DONE has no effect.
- Simultaneous events:
  - i_start while busy is ignored.
  - i_start and i_abort in the same cycle: abort wins when busy; start wins in IDLE/DONE.
  - Changes to i_ch_sel, i_mode, i_delay or i_decim mid-capture have no effect until the next start.
- Read port:
  - Independent of the FSM. i_rd_en at cycle n gives o_rd_data and o_rd_valid=1 at n+1.
  - Without i_rd_en, o_rd_valid=0 and o_rd_data holds its last value.
  - Read and write to the same address in the same cycle returns the old word (read-first).

Test Plan:
- Immediate capture: NUM_CH=4, ch_sel=2, mode 00, decim 0, i_valid[2] every cycle with i_data ch2 = cycle index -> RAM_DEPTH writes, o_done=1 one cycle after the last write, readback adrs k returns first value + k; ch0/1/3 data never appears.
- Decimation/rate: decim=3, i_valid[1] every 2nd cycle, ch_sel=1 -> words stored are valid samples 0,4,8,…; o_wr_count increments once per 8 clk.
- Delayed mode: i_delay=10 -> first write lands exactly 11 cycles after the start cycle (on an always-valid stream); i_delay=0 is identical to mode 00.
- Triggered mode: i_trig high before start -> no capture; drop then raise i_trig -> first sample written in the cycle after the registered edge; o_busy=1 throughout WAIT.
- Abort and restart: abort after 37 writes -> o_busy=0, o_done=0, o_wr_count=37; a new start clears the count to 0 and refills from address 0.
- Reset mid-capture: drive i_reset low asynchronously between clk edges -> all outputs 0 immediately; start honoured after release; read-first collision check returns old data.

Source files
------------

// File: rtl/capture_ctrl_mc.sv
// capture_ctrl_mc
//   Multi-channel capture controller. One of NUM_CH sample streams is chosen
//   at start and written, decimated against its own rate strobe, into an
//   internal RAM_DEPTH-word buffer. A capture starts immediately, after a
//   programmable delay, or on a fresh rising edge of an external trigger.
//   The buffer can be read back at any time through a 1-cycle-latency port.
//
// Ports
//   clk        : system clock, rising edge
//   i_reset    : asynchronous active-low reset
//   i_data     : packed channel samples, channel k at [k*NBT_CH +: NBT_CH]
//   i_valid    : per-channel sample strobe
//   i_ch_sel   : channel to capture (latched at start)
//   i_mode     : 00 immediate, 01 delayed, 10 triggered, 11 as 00 (latched)
//   i_delay    : start delay in clk cycles for mode 01 (latched)
//   i_decim    : keep 1 of (i_decim+1) valid samples (latched)
//   i_trig     : external trigger, rising edge used in mode 10
//   i_start    : one-cycle arm pulse
//   i_abort    : one-cycle abort pulse
//   i_rd_en    : buffer read request
//   i_rd_adrs  : buffer read address
//   o_rd_data  : buffer read data
//   o_rd_valid : read data qualifier
//   o_busy     : high while waiting or capturing
//   o_done     : buffer full
//   o_wr_count : words written by the current capture
module capture_ctrl_mc #(
  parameter int NUM_CH    = 4,
  parameter int NBT_CH    = 32,
  parameter int RAM_DEPTH = 1024,
  parameter int NBT_DELAY = 16,
  parameter int NBT_DEC   = 8
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [NUM_CH*NBT_CH-1:0]      i_data,
  input  logic [NUM_CH-1:0]             i_valid,
  input  logic [$clog2(NUM_CH)-1:0]     i_ch_sel,
  input  logic [1:0]                    i_mode,
  input  logic [NBT_DELAY-1:0]          i_delay,
  input  logic [NBT_DEC-1:0]            i_decim,
  input  logic                          i_trig,
  input  logic                          i_start,
  input  logic                          i_abort,
  input  logic                          i_rd_en,
  input  logic [$clog2(RAM_DEPTH)-1:0]  i_rd_adrs,
  output logic [NBT_CH-1:0]             o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(RAM_DEPTH):0]    o_wr_count
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int AW  = $clog2(RAM_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [NBT_DELAY-1:0] DLY_ONE = NBT_DELAY'(1);
  localparam logic [NBT_DEC-1:0]   DEC_ONE = NBT_DEC'(1);
  localparam logic [AW:0]          WC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]          WC_LAST = (AW+1)'(RAM_DEPTH - 1);

  logic [1:0]           state;
  logic [CHW-1:0]       ch_q;
  logic                 wait_trig;   // WAIT is armed for a trigger, not a delay
  logic [NBT_DELAY-1:0] dly_cnt;
  logic [NBT_DEC-1:0]   decim_q;
  logic [NBT_DEC-1:0]   dec_cnt;
  logic                 trig_q;
  logic                 trig_q_d;
  logic [AW:0]          wr_count;
  logic                 done_q;

  logic [NBT_CH-1:0]    sel_data;
  logic                 sel_valid;
  logic                 trig_edge;
  logic                 start_ok;
  logic                 wr_fire;
  logic                 last_write;

  logic [NBT_CH-1:0]    mem [RAM_DEPTH];

  // Selected-channel mux, driven by the channel latched at start.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == k[CHW-1:0]) begin
        sel_data  = i_data[k*NBT_CH +: NBT_CH];
        sel_valid = i_valid[k];
      end
    end
  end

  assign trig_edge  = trig_q & ~trig_q_d;
  assign start_ok   = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  // Abort takes priority over a sample arriving in the same cycle.
  assign wr_fire    = (state == ST_CAP) && !i_abort && sel_valid && (dec_cnt == '0);
  assign last_write = wr_fire && (wr_count == WC_LAST);

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      ch_q      <= '0;
      wait_trig <= 1'b0;
      dly_cnt   <= '0;
      decim_q   <= '0;
      dec_cnt   <= '0;
      trig_q    <= 1'b0;
      trig_q_d  <= 1'b0;
      wr_count  <= '0;
      done_q    <= 1'b0;
    end else begin
      trig_q   <= i_trig;
      trig_q_d <= trig_q;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            ch_q     <= i_ch_sel;
            decim_q  <= i_decim;
            dec_cnt  <= '0;
            wr_count <= '0;
            done_q   <= 1'b0;
            case (i_mode)
              2'b01: begin
                wait_trig <= 1'b0;
                // A zero delay goes straight to capture so it matches mode 00.
                // Otherwise WAIT lasts exactly i_delay cycles.
                if (i_delay == '0) begin
                  state <= ST_CAP;
                end else begin
                  state   <= ST_WAIT;
                  dly_cnt <= i_delay - DLY_ONE;
                end
              end
              2'b10: begin
                wait_trig <= 1'b1;
                state     <= ST_WAIT;
              end
              default: begin
                wait_trig <= 1'b0;
                state     <= ST_CAP;
              end
            endcase
          end
        end
        ST_WAIT: begin
          if (i_abort) begin
            state <= ST_IDLE;
          end else if (wait_trig) begin
            if (trig_edge) begin
              state   <= ST_CAP;
              dec_cnt <= '0;
            end
          end else if (dly_cnt == '0) begin
            state   <= ST_CAP;
            dec_cnt <= '0;
          end else begin
            dly_cnt <= dly_cnt - DLY_ONE;
          end
        end
        ST_CAP: begin
          if (i_abort) begin
            state <= ST_IDLE;
          end else if (sel_valid) begin
            dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DEC_ONE;
            if (wr_fire) begin
              wr_count <= wr_count + WC_ONE;
            end
            if (last_write) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_count[AW-1:0]] <= sel_data;
    end
  end

  // Read port: i_rd_en in cycle n yields o_rd_valid=1 with o_rd_data in
  // cycle n+1; there is no back-pressure. Data holds between reads. A read
  // colliding with a write to the same address returns the old word.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= mem[i_rd_adrs];
      end
    end
  end

  assign o_busy     = (state == ST_WAIT) || (state == ST_CAP);
  assign o_done     = done_q;
  assign o_wr_count = wr_count;

endmodule

// File: tb/tb_capture_ctrl_mc.sv
// Testbench for capture_ctrl_mc (RAM_DEPTH reduced to 64 for run time).
module tb_capture_ctrl_mc;

  localparam int NCH   = 4;
  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int MAXC  = 8192;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic [NCH*W-1:0]     i_data = '0;
  logic [NCH-1:0]       i_valid = '0;
  logic [1:0]           i_ch_sel = '0;
  logic [1:0]           i_mode = '0;
  logic [15:0]          i_delay = '0;
  logic [7:0]           i_decim = '0;
  logic                 i_trig = 1'b0;
  logic                 i_start = 1'b0;
  logic                 i_abort = 1'b0;
  logic                 i_rd_en = 1'b0;
  logic [5:0]           i_rd_adrs = '0;
  logic [W-1:0]         o_rd_data;
  logic                 o_rd_valid;
  logic                 o_busy;
  logic                 o_done;
  logic [6:0]           o_wr_count;

  capture_ctrl_mc #(
    .NUM_CH(NCH), .NBT_CH(W), .RAM_DEPTH(DEPTH), .NBT_DELAY(16), .NBT_DEC(8)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .i_ch_sel(i_ch_sel), .i_mode(i_mode), .i_delay(i_delay), .i_decim(i_decim),
    .i_trig(i_trig), .i_start(i_start), .i_abort(i_abort), .i_rd_en(i_rd_en),
    .i_rd_adrs(i_rd_adrs), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_busy(o_busy), .o_done(o_done), .o_wr_count(o_wr_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- logs, config, scoreboard ----------------
  logic [NCH*W-1:0] lg_data [MAXC];
  logic [NCH-1:0]   lg_valid [MAXC];
  logic             lg_trig [MAXC];
  logic [6:0]       lg_wc [MAXC];
  logic             lg_busy [MAXC];
  logic             lg_done [MAXC];

  int cfg_ch, cfg_mode, cfg_delay, cfg_decim, vpat;
  bit idx_data, trig_level, trig_rand;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_buf [DEPTH];
  int           wcyc [DEPTH];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (cyc < MAXC) begin
        lg_wc[cyc]   = o_wr_count;
        lg_busy[cyc] = o_busy;
        lg_done[cyc] = o_done;
      end
      if (i_reset && o_rd_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: o_rd_valid=1 data=%h with no read outstanding", o_rd_data);
        end else begin
          e = exp_q.pop_front();
          if (o_rd_data !== e) begin
            bad++;
            $display("FAIL rd_data: got %h, required %h", o_rd_data, e);
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit start, input bit abort, input bit rd, input int adr,
                      input logic [W-1:0] rd_val);
    @(posedge clk); #1;
    if (cyc >= MAXC - 2) begin
      $display("FAIL cycle_budget: cycle %0d, required below %0d", cyc, MAXC - 2);
      $fatal(1, "cycle budget exhausted");
    end
    for (int k = 0; k < NCH; k++) i_data[k*W +: W] = $urandom;
    i_valid = 4'($urandom_range(0, 15));
    case (vpat)
      0: i_valid[cfg_ch] = 1'b1;
      1: i_valid[cfg_ch] = (cyc % 2 == 0);
      default: ;
    endcase
    if (idx_data) i_data[cfg_ch*W +: W] = 32'(cyc);
    i_trig  = trig_rand ? 1'($urandom_range(0, 1)) : trig_level;
    i_start = start;
    i_abort = abort;
    if (start) begin
      i_ch_sel = 2'(cfg_ch);
      i_mode   = 2'(cfg_mode);
      i_delay  = 16'(cfg_delay);
      i_decim  = 8'(cfg_decim);
    end else begin
      i_ch_sel = 2'($urandom_range(0, 3));
      i_mode   = 2'($urandom_range(0, 3));
      i_delay  = 16'($urandom);
      i_decim  = 8'($urandom);
    end
    i_rd_en   = rd;
    i_rd_adrs = 6'(adr);
    if (rd) exp_q.push_back(rd_val);
    lg_data[cyc]  = i_data;
    lg_valid[cyc] = i_valid;
    lg_trig[cyc]  = i_trig;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n = 1;
    step(0, 0, 0, 0, '0);
    while (o_done !== 1'b1 && n < budget) begin
      step(0, 0, 0, 0, '0);
      n++;
    end
    total++;
    if (o_done !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: o_done=%0b after %0d cycles, required 1", name, o_done, n);
    end
    idle(2);
  endtask

  task automatic readback(input int n);
    for (int a = 0; a < n; a++) step(0, 0, 1, a, exp_buf[a]);
    idle(2);
  endtask

  // Reference model: from the logged stimulus and the capture rules, work out
  // which samples land in the buffer and when, then compare the logged
  // o_wr_count / o_busy / o_done traces over cycles s+1..E.
  task automatic check_run(input string name, input int s, input int a, input int E,
                           output int nw, output int last_w);
    int first, stop, k, p, e_wc, mis_wc, mis_busy, mis_done, fc;
    bit filled, e_busy, e_done;
    case (cfg_mode)
      1: first = s + cfg_delay + 1;
      2: begin
        first = E + 1;
        for (int c = s; c <= E; c++) begin
          if (lg_trig[c] && !lg_trig[c-1]) begin
            first = c + 2;
            break;
          end
        end
      end
      default: first = s + 1;
    endcase
    stop = (a >= 0) ? a : E + 1;
    nw = 0;
    k = 0;
    for (int c = first; c < stop && c <= E && nw < DEPTH; c++) begin
      if (lg_valid[c][cfg_ch]) begin
        if (k % (cfg_decim + 1) == 0) begin
          exp_buf[nw] = lg_data[c][cfg_ch*W +: W];
          wcyc[nw] = c;
          nw++;
        end
        k++;
      end
    end
    filled = (nw == DEPTH);
    last_w = filled ? wcyc[DEPTH-1] : 0;
    mis_wc = 0; mis_busy = 0; mis_done = 0; p = 0; fc = -1;
    for (int c = s + 1; c <= E; c++) begin
      while (p < nw && wcyc[p] < c) p++;
      e_wc   = p;
      e_busy = filled ? (c <= last_w) : ((a >= 0) ? (c <= a) : 1'b1);
      e_done = filled && (c > last_w);
      if (lg_wc[c] !== 7'(e_wc)) begin
        if (mis_wc == 0)
          $display("FAIL %s_wr_count: cycle %0d got %0d, required %0d", name, c - s, lg_wc[c], e_wc);
        mis_wc++;
      end
      if (lg_busy[c] !== e_busy) begin
        if (mis_busy == 0)
          $display("FAIL %s_busy: cycle %0d got %0b, required %0b", name, c - s, lg_busy[c], e_busy);
        mis_busy++;
      end
      if (lg_done[c] !== e_done) begin
        if (mis_done == 0)
          $display("FAIL %s_done: cycle %0d got %0b, required %0b", name, c - s, lg_done[c], e_done);
        mis_done++;
      end
    end
    total += 3;
    bad += (mis_wc != 0) + (mis_busy != 0) + (mis_done != 0);
  endtask

  task automatic reset_mid();
    @(posedge clk); #3;
    i_reset = 1'b0;
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_done", o_done, 0);
    chk("rst_mid_wr_count", o_wr_count, 0);
    chk("rst_mid_rd_data", o_rd_data, 0);
    chk("rst_mid_rd_valid", o_rd_valid, 0);
    #2;
    i_reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, a, E, nw, lw, tr;
    cfg_ch = 0; cfg_mode = 0; cfg_delay = 0; cfg_decim = 0;
    vpat = 0; idx_data = 0; trig_level = 0; trig_rand = 0;
    fork
      monitor();
    join_none

    #2 i_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_wr_count", o_wr_count, 0);
    chk("reset_rd_valid", o_rd_valid, 0);
    chk("reset_rd_data", o_rd_data, 0);
    i_reset = 1'b1;
    idle(2);

    // Immediate capture, ch2 carries the cycle index; abort in IDLE is a no-op.
    cfg_ch = 2; cfg_mode = 0; cfg_decim = 0; vpat = 0; idx_data = 1;
    step(0, 1, 0, 0, '0);
    step(1, 0, 0, 0, '0); s = cyc;
    run_until_done("imm", 200);
    E = cyc - 1;
    check_run("imm", s, -1, E, nw, lw);
    chk("imm_done_before", lg_done[lw], 0);
    chk("imm_done_after", lg_done[lw+1], 1);
    chk("imm_first_word_cycle", lg_wc[s+2], 1);
    readback(nw);

    // Decimation 3, ch1 valid every 2nd cycle; start+abort together in DONE.
    cfg_ch = 1; cfg_decim = 3; vpat = 1; idx_data = 0;
    step(1, 1, 0, 0, '0); s = cyc;
    chk("dec_start_wins", o_busy, 0);
    run_until_done("dec", 1200);
    E = cyc - 1;
    check_run("dec", s, -1, E, nw, lw);
    chk("dec_period", lg_wc[wcyc[10]+1] - lg_wc[wcyc[2]+1], 8);
    readback(nw);

    // Delayed mode, delay 10: first write in the edge ending cycle s+11.
    cfg_ch = 3; cfg_mode = 1; cfg_delay = 10; cfg_decim = 0; vpat = 0;
    step(1, 0, 0, 0, '0); s = cyc;
    run_until_done("dly10", 200);
    E = cyc - 1;
    check_run("dly10", s, -1, E, nw, lw);
    chk("dly10_before", lg_wc[s+11], 0);
    chk("dly10_after", lg_wc[s+12], 1);
    readback(nw);

    // Delay 0 behaves as immediate.
    cfg_delay = 0;
    step(1, 0, 0, 0, '0); s = cyc;
    run_until_done("dly0", 200);
    E = cyc - 1;
    check_run("dly0", s, -1, E, nw, lw);
    chk("dly0_first", lg_wc[s+2], 1);
    readback(nw);

    // Triggered: trigger high before start must not fire; ignored start while busy.
    cfg_ch = 0; cfg_mode = 2; vpat = 0; trig_level = 1;
    idle(3);
    step(1, 0, 0, 0, '0); s = cyc;
    idle(10);
    step(1, 0, 0, 0, '0);
    idle(5);
    chk("trig_held_no_capture", lg_wc[cyc-1], 0);
    chk("trig_wait_busy", lg_busy[cyc-1], 1);
    trig_level = 0;
    idle(3);
    trig_level = 1;
    step(0, 0, 0, 0, '0); tr = cyc;
    run_until_done("trig", 200);
    E = cyc - 1;
    check_run("trig", s, -1, E, nw, lw);
    chk("trig_before", lg_wc[tr+2], 0);
    chk("trig_after", lg_wc[tr+3], 1);
    readback(nw);

    // Abort after 37 writes, then restart with a read-first collision at adrs 5.
    cfg_ch = 2; cfg_mode = 0; cfg_decim = 0; vpat = 0;
    step(1, 0, 0, 0, '0); s = cyc;
    idle(37);
    step(0, 1, 0, 0, '0); a = cyc;
    idle(3);
    E = cyc - 1;
    check_run("abort", s, a, E, nw, lw);
    chk("abort_wr_count", lg_wc[E], 37);
    chk("abort_busy", lg_busy[E], 0);
    chk("abort_done", lg_done[E], 0);
    readback(nw);
    cfg_ch = 3;
    step(1, 0, 0, 0, '0); s = cyc;
    idle(5);
    step(0, 0, 1, 5, exp_buf[5]);
    run_until_done("restart", 200);
    E = cyc - 1;
    check_run("restart", s, -1, E, nw, lw);
    chk("restart_cleared", lg_wc[s+1], 0);
    readback(nw);

    // Asynchronous reset mid-capture, then a fresh start.
    cfg_ch = 1; cfg_mode = 0;
    step(1, 0, 0, 0, '0);
    idle(20);
    reset_mid();
    idle(2);
    cfg_mode = 1; cfg_delay = 3; cfg_decim = 1; vpat = 2;
    step(1, 0, 0, 0, '0); s = cyc;
    run_until_done("post_rst", 800);
    E = cyc - 1;
    check_run("post_rst", s, -1, E, nw, lw);
    readback(nw);

    // Randomised configurations with random trigger activity.
    trig_rand = 1;
    for (int r = 0; r < 4; r++) begin
      cfg_ch    = $urandom_range(0, 3);
      cfg_mode  = $urandom_range(0, 3);
      cfg_delay = $urandom_range(0, 20);
      cfg_decim = $urandom_range(0, 3);
      vpat      = $urandom_range(0, 2);
      step(1, 0, 0, 0, '0); s = cyc;
      run_until_done("rand", 2000);
      E = cyc - 1;
      check_run("rand", s, -1, E, nw, lw);
      readback(nw);
    end

    idle(3);
    chk("rd_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
